// File: rtl/timer_pkg.sv
// Shared constants and helpers for the multi-channel prescaled timer.
package timer_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Prescaler counter width: wide enough for the largest divide ratio 2^(2^SB-1).
    function automatic int unsigned pcnt_width(input int unsigned scaler_bits);
        return (32'd1 << scaler_bits) - 32'd1;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer slice: prescaler, down-counter, one-shot halt, tick pulse and sticky done flag.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SCALER_BITS = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   mode_i,
    input  logic                   load_i,
    input  logic [SCALER_BITS-1:0] ps_i,
    input  logic [WIDTH-1:0]       d_i,
    input  logic                   ack_i,
    output logic [WIDTH-1:0]       q_o,
    output logic                   tick_o,
    output logic                   done_o
);

    localparam int unsigned PW = pcnt_width(SCALER_BITS);

    logic [WIDTH-1:0] q_q, q_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             halted_q, halted_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic [PW-1:0]    mask;
    logic             active;
    logic             strobe;

    // Next-state: load beats strobe; a strobe at zero expires the channel.
    always_comb begin
        q_d      = q_q;
        pcnt_d   = pcnt_q;
        halted_d = halted_q;
        tick_d   = 1'b0;
        mask     = '0;
        for (int k = 0; k < int'(PW); k++) begin
            mask[k] = (k < int'(ps_i));
        end
        active = en_i && !((mode_i == MODE_ONESHOT) && halted_q);
        // ps==0 gives an empty mask, so the strobe fires every active cycle.
        strobe = active && (&(pcnt_q | ~mask));

        if (load_i) begin
            q_d      = d_i;
            pcnt_d   = '0;
            halted_d = 1'b0;
        end else if (active) begin
            pcnt_d = pcnt_q + PW'(1);
            if (strobe) begin
                if (q_q != '0) begin
                    q_d = q_q - WIDTH'(1);
                end else begin
                    tick_d = 1'b1;
                    if (mode_i == MODE_PERIODIC) begin
                        q_d = d_i;
                    end else begin
                        halted_d = 1'b1;
                    end
                end
            end
        end
        done_d = tick_d | (done_q & ~ack_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q      <= '0;
            pcnt_q   <= '0;
            halted_q <= 1'b1;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            q_q      <= q_d;
            pcnt_q   <= pcnt_d;
            halted_q <= halted_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    assign q_o    = q_q;
    assign tick_o = tick_q;
    assign done_o = done_q;

endmodule

// File: rtl/timer_multi.sv
// CHANNELS independent prescaled down-counters with a combined interrupt line.
module timer_multi
    import timer_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SCALER_BITS = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CHANNELS-1:0]             en,
    input  logic [CHANNELS-1:0]             mode,
    input  logic [CHANNELS-1:0]             load,
    input  logic [CHANNELS*SCALER_BITS-1:0] ps,
    input  logic [CHANNELS*WIDTH-1:0]       d_in,
    input  logic [CHANNELS-1:0]             ack,
    output logic [CHANNELS*WIDTH-1:0]       q,
    output logic [CHANNELS-1:0]             tick,
    output logic [CHANNELS-1:0]             done,
    output logic                            irq
);

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        timer_channel #(
            .WIDTH       (WIDTH),
            .SCALER_BITS (SCALER_BITS)
        ) u_ch (
            .clk_i  (clk),
            .rst_i  (rst),
            .en_i   (en[i]),
            .mode_i (mode[i]),
            .load_i (load[i]),
            .ps_i   (ps[i*SCALER_BITS +: SCALER_BITS]),
            .d_i    (d_in[i*WIDTH +: WIDTH]),
            .ack_i  (ack[i]),
            .q_o    (q[i*WIDTH +: WIDTH]),
            .tick_o (tick[i]),
            .done_o (done[i])
        );
    end

    // done flags are registered, so the OR adds no extra stage.
    assign irq = |done;

endmodule

// File: tb/tb_timer_multi.sv
// Randomized and directed stimulus for timer_multi, scored against a cycle-level reference model.
module tb_timer_multi;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int SB = 3;
    localparam int PCNT_MOD = 128;

    typedef struct packed {
        logic [CH*W-1:0] q;
        logic [CH-1:0]   tick;
        logic [CH-1:0]   done;
        logic            irq;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   en, mode, load, ack;
    logic [CH*SB-1:0] ps;
    logic [CH*W-1:0] d_in;
    logic [CH*W-1:0] q;
    logic [CH-1:0]   tick, done;
    logic            irq;

    int total = 0;
    int bad   = 0;
    bit stim_done = 1'b0;
    exp_t exp_q[$];

    // Reference state: value, active cycles since load/reset, halted flag, flags.
    int m_val[CH];
    int m_el[CH];
    bit m_halt[CH];
    bit m_tick[CH];
    bit m_done[CH];

    timer_multi #(.CHANNELS(CH), .WIDTH(W), .SCALER_BITS(SB)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .ps(ps),
        .d_in(d_in), .ack(ack), .q(q), .tick(tick), .done(done), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        exp_t e;
        int div, pv, dv;
        e = '0;
        for (int i = 0; i < CH; i++) begin
            pv  = int'(ps[i*SB +: SB]);
            dv  = int'(d_in[i*W +: W]);
            div = 1 << pv;
            if (rst) begin
                m_val[i] = 0; m_el[i] = 0; m_halt[i] = 1; m_tick[i] = 0; m_done[i] = 0;
            end else begin
                m_tick[i] = 0;
                if (load[i]) begin
                    m_val[i] = dv; m_el[i] = 0; m_halt[i] = 0;
                end else if (en[i] && !(mode[i] && m_halt[i])) begin
                    if (m_el[i] % div == div - 1) begin
                        if (m_val[i] > 0) m_val[i] = m_val[i] - 1;
                        else begin
                            m_tick[i] = 1;
                            if (mode[i]) m_halt[i] = 1;
                            else m_val[i] = dv;
                        end
                    end
                    m_el[i] = (m_el[i] + 1) % PCNT_MOD;
                end
                m_done[i] = m_tick[i] || (m_done[i] && !ack[i]);
            end
            e.q[i*W +: W] = W'(m_val[i]);
            e.tick[i]     = m_tick[i];
            e.done[i]     = m_done[i];
            e.irq         = e.irq | m_done[i];
        end
        exp_q.push_back(e);
    endtask

    // Apply current inputs for one clock, then drop the pulse inputs.
    task automatic step();
        model_step();
        @(negedge clk);
        load = '0;
        ack  = '0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_ch(input int i, input logic m, input int p, input int d);
        mode[i]         = m;
        ps[i*SB +: SB]  = SB'(p);
        d_in[i*W +: W]  = W'(d);
    endtask

    // Monitor: every cycle the DUT presents a full output set, compared against the oldest expectation.
    initial begin : monitor
        exp_t e;
        int guard = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (q !== e.q) begin
                    bad++; $display("FAIL q: got %h expected %h at %0t", q, e.q, $time);
                end
                total++;
                if (tick !== e.tick) begin
                    bad++; $display("FAIL tick: got %b expected %b at %0t", tick, e.tick, $time);
                end
                total++;
                if (done !== e.done) begin
                    bad++; $display("FAIL done: got %b expected %b at %0t", done, e.done, $time);
                end
                total++;
                if (irq !== e.irq) begin
                    bad++; $display("FAIL irq: got %b expected %b at %0t", irq, e.irq, $time);
                end
            end else if (stim_done) begin
                guard++;
                if (guard > 2) begin
                    $display("test done: total=%0d bad=%0d", total, bad);
                    $finish;
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; en = '0; mode = '0; load = '0; ack = '0; ps = '0; d_in = '0;
        @(negedge clk);
        step();
        rst = 1'b0;
        // ch0 periodic ps=4 d=FF from reset; ch1 periodic; ch2 one-shot; ch3 periodic every cycle.
        set_ch(0, 1'b0, 4, 8'hFF);
        set_ch(1, 1'b0, 0, 3);
        set_ch(2, 1'b1, 1, 2);
        set_ch(3, 1'b0, 0, 0);
        en = '1;
        run(15);
        total++;
        if (tick[0] !== 1'b0) begin
            bad++; $display("FAIL tick0_early: got %b expected 0", tick[0]);
        end
        run(1);
        total++;
        if (tick[0] !== 1'b1) begin
            bad++; $display("FAIL tick0_first: got %b expected 1", tick[0]);
        end
        // Two full 4096-cycle periods of ch0.
        run(8200);
        load[1] = 1'b1; step(); run(12);
        load[2] = 1'b1; step(); run(12);
        load[2] = 1'b1; step(); run(12);
        en[0] = 1'b0; run(10); en[0] = 1'b1; run(40);
        // ch3 strobes at zero every cycle: a load there collides with an expiry.
        set_ch(3, 1'b0, 0, 5); load[3] = 1'b1; step(); run(3);
        set_ch(3, 1'b0, 0, 0); load[3] = 1'b1; step(); run(1);
        ack[3] = 1'b1; run(2);
        ack[0] = 1'b1; run(2);
        rst = 1'b1; step(); rst = 1'b0;
        total++;
        if (done !== '0 || irq !== 1'b0 || tick !== '0 || q !== '0) begin
            bad++; $display("FAIL mid_reset: q=%h tick=%b done=%b irq=%b expected all zero", q, tick, done, irq);
        end
        run(20);
        // Randomized phase.
        for (int c = 0; c < 6000; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(99) < 10) en[i] = ~en[i];
                if ($urandom_range(99) < 2)  mode[i] = ~mode[i];
                if ($urandom_range(99) < 3)  load[i] = 1'b1;
                if ($urandom_range(99) < 10) ack[i] = 1'b1;
                if ($urandom_range(99) < 2)
                    ps[i*SB +: SB] = SB'(($urandom_range(9) == 0) ? $urandom_range(7) : $urandom_range(2));
                if ($urandom_range(99) < 5)  d_in[i*W +: W] = W'($urandom_range(12));
            end
            rst = ($urandom_range(999) == 0);
            step();
            rst = 1'b0;
        end
        stim_done = 1'b1;
    end

    // Absolute bound so the run can never hang.
    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
